vga_fb_scanout: RTL

- Initiator for the 16-bit VGA read port of the 1-Mbit SPRAM framebuffer. Drives the request, word-address and read-data signals: request/address out, data in.
- Generates 640x480 VGA timing, prefetches framebuffer words into a small FIFO and emits RGB332 pixels.
- Framebuffer is 320x240 bytes, one byte per pixel, doubled in both axes.
- Its requests take priority over Wishbone traffic, so the fetch cadence is deterministic.

---
 rtl/vga_pkg.sv | 22 ++
 rtl/vga_word_fifo.sv | 41 ++++
 rtl/vga_fb_scanout.sv | 102 ++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: 640x480 timing, RGB332 field positions and framebuffer geometry
package vga_pkg;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP = 33;
  localparam int VGA_FB_WIDTH = 320;
  localparam int VGA_FB_HEIGHT = 240;
  localparam int VGA_WORDS_PER_LINE = VGA_FB_WIDTH / 2;
  localparam logic [15:0] VGA_FB_BASE = 16'h0000;
  localparam int VGA_FIFO_DEPTH = 4;
  localparam int VGA_RED_HI = 7;
  localparam int VGA_RED_LO = 5;
  localparam int VGA_GRN_HI = 4;
  localparam int VGA_GRN_LO = 2;
  localparam int VGA_BLU_HI = 1;
  localparam int VGA_BLU_LO = 0;
endpackage

// File: rtl/vga_word_fifo.sv
// vga_word_fifo: 16-bit prefetch FIFO with push/pop/flush, flush beats push
module vga_word_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH = VGA_FIFO_DEPTH,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input  logic          I_clk,
  input  logic          I_reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata,
  output logic [CW-1:0] count,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);
  logic [15:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign rdata = mem[rd_ptr];
  assign empty = count == '0;
  // storage write; a flushed push is dropped
  always_ff @(posedge I_clk)
    if (push && !flush) mem[wr_ptr] <= wdata;
  // pointers and occupancy
  always_ff @(posedge I_clk or negedge I_reset_n)
    if (!I_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout: VGA timing, framebuffer prefetch over the SPRAM read port, RGB332 out
module vga_fb_scanout
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP = VGA_V_BP,
  parameter logic [15:0] FB_BASE = VGA_FB_BASE,
  parameter int WORDS_PER_LINE = VGA_WORDS_PER_LINE,
  parameter int FIFO_DEPTH = VGA_FIFO_DEPTH
) (
  input  logic        I_clk,
  input  logic        I_reset_n,
  output logic        O_vga_req,
  output logic [15:0] O_vga_adr,
  input  logic [15:0] I_vga_dat,
  output logic        O_hsync,
  output logic        O_vsync,
  output logic [2:0]  O_red,
  output logic [2:0]  O_green,
  output logic [1:0]  O_blue,
  output logic        O_underflow
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] HA = 16'(H_ACTIVE);
  localparam logic [15:0] HT = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [15:0] HS0 = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS1 = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] VA = 16'(V_ACTIVE);
  localparam logic [15:0] VT = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [15:0] VS0 = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS1 = 16'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [15:0] WPL = 16'(WORDS_PER_LINE);
  localparam logic [15:0] DEP = 16'(FIFO_DEPTH);
  logic [15:0] hcount, vcount, ptr, row_base, remaining;
  logic [15:0] nv, eff_base, eff_ptr, eff_rem, cnt_next, head;
  logic [CW-1:0] count;
  logic [7:0] pix, rgb;
  logic cap, trig, load, active, issue, pop, empty;
  vga_word_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .I_clk(I_clk), .I_reset_n(I_reset_n), .push(cap), .pop(pop), .flush(load),
    .wdata(I_vga_dat), .rdata(head), .count(count), .empty(empty)
  );
  // line-fetch trigger, issue decision and pixel selection; a loading line sees an empty FIFO
  always_comb begin
    trig = hcount == HA;
    nv = vcount == VT - 16'd1 ? 16'd0 : vcount + 16'd1;
    load = trig && nv < VA;
    eff_base = nv == 16'd0 ? FB_BASE : row_base;
    eff_ptr = load ? eff_base : ptr;
    eff_rem = load ? WPL : trig ? 16'd0 : remaining;
    active = hcount < HA && vcount < VA;
    pop = active && hcount[1:0] == 2'd3 && !empty;
    cnt_next = load ? 16'd0 : 16'(count) + 16'(cap) - 16'(pop);
    issue = eff_rem != 16'd0 && !O_vga_req && cnt_next < DEP;
    pix = hcount[1] ? head[7:0] : head[15:8];
    rgb = active && !empty ? pix : 8'd0;
  end
  // counters, fetch pointer and request; a capture pending across a flush is discarded
  always_ff @(posedge I_clk or negedge I_reset_n)
    if (!I_reset_n) begin
      hcount <= HA;
      vcount <= VT - 16'd1;
      ptr <= FB_BASE;
      row_base <= FB_BASE;
      remaining <= 16'd0;
      O_vga_req <= 1'b0;
      O_vga_adr <= 16'd0;
      cap <= 1'b0;
    end else begin
      hcount <= hcount == HT - 16'd1 ? 16'd0 : hcount + 16'd1;
      if (hcount == HT - 16'd1) vcount <= nv;
      if (load) row_base <= eff_base + (nv[0] ? WPL : 16'd0);
      ptr <= issue ? eff_ptr + 16'd1 : eff_ptr;
      remaining <= issue ? eff_rem - 16'd1 : eff_rem;
      O_vga_req <= issue;
      if (issue) O_vga_adr <= eff_ptr;
      cap <= O_vga_req && !load;
    end
  // syncs and RGB registered together, one cycle behind the counters
  always_ff @(posedge I_clk or negedge I_reset_n)
    if (!I_reset_n) begin
      O_hsync <= 1'b1;
      O_vsync <= 1'b1;
      O_red <= 3'd0;
      O_green <= 3'd0;
      O_blue <= 2'd0;
      O_underflow <= 1'b0;
    end else begin
      O_hsync <= !(hcount >= HS0 && hcount < HS1);
      O_vsync <= !(vcount >= VS0 && vcount < VS1);
      O_red <= rgb[VGA_RED_HI:VGA_RED_LO];
      O_green <= rgb[VGA_GRN_HI:VGA_GRN_LO];
      O_blue <= rgb[VGA_BLU_HI:VGA_BLU_LO];
      if (active && empty) O_underflow <= 1'b1;
    end
endmodule
